// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter between the fetch (F) and data (C) stages.
// One transaction outstanding at a time. Data has priority over fetch, and a
// starvation counter bounds how many data grants can pass a waiting fetch.
// A branch flush drops the response of an owned in-flight fetch.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       owner_fetch;
  logic       drop;
  logic       starved;

  // Combinational grant in IDLE; gated by reset so both grants read 0 while
  // the arbiter is held in reset.
  always_comb begin
    starved = i_req && (starve_cnt == MAX_CNT);
    d_gnt   = reset && (state == IDLE) && d_req && !starved;
    i_gnt   = reset && (state == IDLE) && i_req && !(d_req && !starved);
  end

  // Arbiter FSM with registered memory-side and response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      owner_fetch <= 1'b0;
      drop        <= 1'b0;
      i_rvalid    <= 1'b0;
      i_rdata     <= '0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      busy        <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_req) begin
            starve_cnt <= '0;
          end else if (d_gnt) begin
            if (starve_cnt < MAX_CNT) starve_cnt <= starve_cnt + 4'd1;
          end else if (i_gnt) begin
            starve_cnt <= '0;
          end

          if (d_gnt) begin
            owner_fetch <= 1'b0;
            m_we        <= d_we;
            m_addr      <= d_addr;
            m_wdata     <= d_wdata;
            m_req       <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end else if (i_gnt) begin
            owner_fetch <= 1'b1;
            m_we        <= 1'b0;
            m_addr      <= i_addr;
            m_wdata     <= '0;
            m_req       <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (owner_fetch && i_flush) drop <= 1'b1;
          if (m_ready) begin
            m_req <= 1'b0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (m_rvalid) begin
            // A flush arriving with the response suppresses it directly,
            // since the drop flag would only take effect a cycle late.
            if (owner_fetch) begin
              if (!drop && !i_flush) begin
                i_rvalid <= 1'b1;
                i_rdata  <= m_rdata;
              end
            end else begin
              d_rvalid <= 1'b1;
              d_rdata  <= m_rdata;
            end
            drop  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (owner_fetch && i_flush) begin
            drop <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared memory-port arbiter between the F stage (instruction fetch) and the C stage (data load/store). It serialises both requesters onto one external memory port with one transaction outstanding at a time. Data accesses have priority over fetches, and a bounded-starvation counter guarantees that fetches make progress. A branch-flush input discards in-flight fetch responses so that F never receives stale instructions.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (instruction and data word)
- MAX_WAIT, 3, maximum consecutive data grants while a fetch is pending (1..15)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_flush  in  1  branch taken; discard any owned fetch response
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data / store ack (1-cycle pulse)
- d_rdata  out  DATA_W  load data (store: don't-care)
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ready  in  1  memory accepts m_req this cycle
- m_rvalid  in  1  memory response (reads and write acks)
- m_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration (combinational grant):
  - If d_req and not (i_req and starve_cnt==MAX_WAIT): grant data.
  - Otherwise, if i_req: grant fetch.
  - Exactly one gnt is high, only in IDLE. On grant, latch owner, we, addr and wdata, then go to ISSUE. A fetch latches we=0 and wdata=0.
- starve_cnt (4 bits):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, and clears when i_req=0 in an IDLE cycle.
  - Saturates at MAX_WAIT.
- ISSUE: m_req=1 with the latched fields held stable. On m_ready=1, go to WAIT; otherwise stay.
- WAIT: m_req=0. On m_rvalid=1, register m_rdata and pulse the owner's rvalid next cycle, then go to IDLE.
- Flush: i_flush=1 while owner=fetch in ISSUE or WAIT sets the drop flag.
  - A dropped transaction still completes on the memory side, but i_rvalid is suppressed.
  - The drop flag clears on return to IDLE.
  - i_flush in IDLE, or while owner=data, has no effect.
  - i_flush in the same cycle as m_rvalid suppresses that response.
- Requesters may change req/addr after gnt; the latched copy is used.
- m_rvalid in IDLE/ISSUE is a protocol error and is ignored.

## Timing
- Reset values: state=IDLE, starve_cnt=0, drop=0, all outputs 0 (gnt, rvalid, rdata, m_* and busy).
- Best-case latency, with req at cycle 0 in IDLE:
  - gnt at cycle 0
  - m_req at cycle 1
  - m_ready=1 at cycle 1, so WAIT at cycle 2
  - m_rvalid at cycle 2, so owner rvalid and rdata at cycle 3
  - State is IDLE at cycle 3, and a new grant is possible in cycle 3
- Back-to-back throughput is 3 cycles per transaction with zero-wait memory.
- rvalid is a single-cycle pulse. rdata holds its value until the next response.
- m_req never drops in ISSUE until m_ready is seen.
- Reset asserted mid-transaction: immediate return to reset values. The pending transaction is abandoned, and memory is reset in the same domain.

## Test plan
- Single load: d_req, d_addr=0x100, m_ready and m_rvalid immediate with m_rdata=0xDEADBEEF -> d_gnt at c0, m_req/m_addr=0x100 at c1, d_rvalid=1 and d_rdata=0xDEADBEEF at c3, i_rvalid stays 0.
- Simultaneous requests: i_req and d_req both high at c0 -> d_gnt first, i_gnt at the next IDLE (c3), responses routed to the correct owners.
- Starvation bound: d_req held high and i_req held high, MAX_WAIT=3 -> grant order D,D,D,I,D,D,D,I, with no more than 3 data grants between fetch grants.
- Memory wait states: m_ready low for 4 cycles, then m_rvalid 5 cycles after acceptance -> m_req, m_addr and m_we stable throughout, exactly one rvalid pulse, busy high the whole time.
- Flush: fetch 0x40 in WAIT, i_flush pulsed, then m_rvalid -> no i_rvalid pulse, arbiter returns to IDLE. Flush in the same cycle as m_rvalid -> also suppressed. Flush during a data transaction -> d_rvalid still delivered.
- Reset mid-transaction: reset=0 during ISSUE -> m_req, gnt and busy drop to 0 immediately, starve_cnt=0. After release, a fresh request proceeds normally.
